cpu_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 32-bit micro CPU. It owns the PC, fetches instructions over a req/ack instruction-memory port and latches them into the instruction register that feeds the decoder. It steps the decoded instruction through execute, data-memory and writeback phases, and issues one-cycle register-file and status-register write strobes. It sits between instruction memory, the decoder, the register file/ALU and data memory.

---
 rtl/cpu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer for the 32-bit micro CPU.
// It owns the PC, fetches over a req/ack instruction port into the
// instruction register, and steps each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB. It issues one-cycle
// register-file and status-register write strobes in WB.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   run                  level enable; low parks the FSM in IDLE between instructions
//   imem_req/addr/ack/rdata  instruction fetch handshake (addr = pc)
//   instr                instruction register, to the decoder
//   ctrl_*               decoder controls (reg write, branch, jump target, mem rd/wr)
//   dmem_req/we/ack      data memory handshake
//   rf_we, status_we     one-cycle write strobes issued in WB
//   illegal_op           one-cycle pulse in WB for an undefined opcode
//   pc, state            current PC and FSM state encoding
//   instr_count          retired-instruction counter (wraps at 2^32)
//   err                  sticky ack-timeout error
//
// Build option: define SEQ_TIMEOUT_EN to enable the ack-timeout watchdog
// (TIMEOUT_CYCLES). Without it the FSM waits indefinitely and err is 0.
module cpu_sequencer #(
   parameter int unsigned         PC_WIDTH       = 26,
   parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
   parameter int unsigned         TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [31:0]         imem_rdata,
   output logic [31:0]         instr,
   input  logic                ctrl_reg_we,
   input  logic                ctrl_load_pc,
   input  logic [PC_WIDTH-1:0] ctrl_load_pc_val,
   input  logic                ctrl_mem_rd,
   input  logic                ctrl_mem_wr,
   output logic                dmem_req,
   output logic                dmem_we,
   input  logic                dmem_ack,
   output logic                rf_we,
   output logic                status_we,
   output logic                illegal_op,
   output logic [PC_WIDTH-1:0] pc,
   output logic [2:0]          state,
   output logic [31:0]         instr_count,
   output logic                err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   localparam logic [5:0] OP_CMP = 6'h0A;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]         instr_q, instr_d;
   logic [31:0]         count_q, count_d;
   logic [5:0]          opcode;
   logic                op_defined;

   assign opcode     = instr_q[31:26];
   // Defined opcodes are 0x00-0x16 with the single hole at 0x09.
   assign op_defined = (opcode <= 6'h16) && (opcode != 6'h09);

`ifdef SEQ_TIMEOUT_EN
   logic [31:0] wait_q, wait_d;
   logic        timeout;
   assign timeout = ((wait_q + 32'd1) == 32'(TIMEOUT_CYCLES));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      count_d = count_q;
`ifdef SEQ_TIMEOUT_EN
      wait_d  = wait_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_DECODE;
            end
`ifdef SEQ_TIMEOUT_EN
            else if (timeout) state_d = S_ERROR;
            else              wait_d  = wait_q + 32'd1;
`endif
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (op_defined && (ctrl_mem_rd || ctrl_mem_wr)) state_d = S_MEM;
            else                                            state_d = S_WB;
         end
         S_MEM: begin
            if (dmem_ack) state_d = S_WB;
`ifdef SEQ_TIMEOUT_EN
            else if (timeout) state_d = S_ERROR;
            else              wait_d  = wait_q + 32'd1;
`endif
         end
         S_WB: begin
            pc_d    = (op_defined && ctrl_load_pc) ? ctrl_load_pc_val
                                                   : pc_q + PC_WIDTH'(1);
            count_d = count_q + 32'd1;
            state_d = run ? S_FETCH : S_IDLE;
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase
`ifdef SEQ_TIMEOUT_EN
      // Any state change clears the counter, which covers entry to FETCH/MEM.
      if (state_d != state_q) wait_d = '0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         count_q <= '0;
`ifdef SEQ_TIMEOUT_EN
         wait_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         count_q <= count_d;
`ifdef SEQ_TIMEOUT_EN
         wait_q  <= wait_d;
`endif
      end
   end

   // Strobes decode directly from the state register so an async reset
   // silences them immediately.
   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign dmem_req    = (state_q == S_MEM);
   assign dmem_we     = (state_q == S_MEM) && ctrl_mem_wr;
   assign rf_we       = (state_q == S_WB) && op_defined && ctrl_reg_we;
   assign status_we   = (state_q == S_WB) && (opcode == OP_CMP);
   assign illegal_op  = (state_q == S_WB) && !op_defined;
   assign instr       = instr_q;
   assign pc          = pc_q;
   assign state       = state_q;
   assign instr_count = count_q;
`ifdef SEQ_TIMEOUT_EN
   assign err = (state_q == S_ERROR);
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: directed scenarios followed by randomized
// instructions, checked against a per-instruction transaction model.
module tb_cpu_sequencer;
   localparam int unsigned PCW = 26;

   logic            clk = 1'b0;
   logic            rst_n, run;
   logic            imem_req, imem_ack;
   logic [PCW-1:0]  imem_addr;
   logic [31:0]     imem_rdata, instr;
   logic            ctrl_reg_we, ctrl_load_pc, ctrl_mem_rd, ctrl_mem_wr;
   logic [PCW-1:0]  ctrl_load_pc_val;
   logic            dmem_req, dmem_we, dmem_ack;
   logic            rf_we, status_we, illegal_op, err;
   logic [PCW-1:0]  pc;
   logic [2:0]      state;
   logic [31:0]     instr_count;

   int unsigned     n_checks = 0;
   int unsigned     n_errors = 0;
   logic [PCW-1:0]  m_pc;
   logic [31:0]     m_count;

   cpu_sequencer #(
      .PC_WIDTH(PCW),
      .RESET_PC('0),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr(instr),
      .ctrl_reg_we(ctrl_reg_we), .ctrl_load_pc(ctrl_load_pc),
      .ctrl_load_pc_val(ctrl_load_pc_val), .ctrl_mem_rd(ctrl_mem_rd),
      .ctrl_mem_wr(ctrl_mem_wr), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_ack(dmem_ack), .rf_we(rf_we), .status_we(status_we),
      .illegal_op(illegal_op), .pc(pc), .state(state),
      .instr_count(instr_count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction starting from a cycle where the DUT should be in FETCH.
   task automatic do_instr(input logic [31:0] word, input logic reg_we, input logic load_pc,
                           input logic [PCW-1:0] target, input logic rd, input logic wr,
                           input int unsigned iwait, input int unsigned dwait, input logic park);
      logic [5:0]     op;
      bit             defined, mem;
      int unsigned    n, icnt, dcnt, ireq_n, dreq_n, dwe_n, rf_n, st_n, ill_n;
      int             rf_at;
      logic [PCW-1:0] exp_pc;
      op      = word[31:26];
      defined = (op <= 6'h16) && (op != 6'h09);
      mem     = defined && (rd || wr);
      n       = 4 + iwait + (mem ? 1 + dwait : 0);
      exp_pc  = (defined && load_pc) ? target : PCW'(m_pc + 1);
      icnt = 0; dcnt = 0; ireq_n = 0; dreq_n = 0; dwe_n = 0;
      rf_n = 0; st_n = 0; ill_n = 0; rf_at = -1;
      ctrl_reg_we = reg_we; ctrl_load_pc = load_pc; ctrl_load_pc_val = target;
      ctrl_mem_rd = rd; ctrl_mem_wr = wr;
      check_val("fetch_req", 32'(imem_req), 32'd1);
      check_val("fetch_addr", 32'(imem_addr), 32'(m_pc));
      for (int c = 0; c < int'(n); c++) begin
         if (imem_req) begin
            ireq_n++;
            imem_ack   = (icnt == iwait);
            imem_rdata = imem_ack ? word : $urandom;
            icnt++;
         end else begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
         end
         if (dmem_req) begin
            dreq_n++;
            dmem_ack = (dcnt == dwait);
            dcnt++;
         end else begin
            dmem_ack = 1'($urandom_range(0, 1));
         end
         if (dmem_we)    dwe_n++;
         if (rf_we)      begin rf_n++; rf_at = c; end
         if (status_we)  st_n++;
         if (illegal_op) ill_n++;
         if (park && (dmem_req || (!mem && c == 1))) run = 1'b0;
         step();
      end
      m_pc = exp_pc;
      m_count++;
      check_val("imem_req_cycles", ireq_n, 1 + iwait);
      check_val("dmem_req_cycles", dreq_n, mem ? 1 + dwait : 0);
      check_val("dmem_we_cycles", dwe_n, (mem && wr) ? 1 + dwait : 0);
      check_val("rf_we_pulses", rf_n, (defined && reg_we) ? 1 : 0);
      if (defined && reg_we) check_val("rf_we_cycle", 32'(rf_at), n - 1);
      check_val("status_we_pulses", st_n, (op == 6'h0A) ? 1 : 0);
      check_val("illegal_pulses", ill_n, defined ? 0 : 1);
      check_val("end_state", 32'(state), park ? 32'd0 : 32'd1);
      check_val("pc", 32'(pc), 32'(m_pc));
      check_val("instr_count", instr_count, m_count);
      check_val("instr", instr, word);
   endtask

   // After a parked instruction: confirm IDLE is quiet, then restart.
   task automatic resume();
      for (int i = 0; i < 2; i++) begin
         imem_ack = 1'b1;
         step();
         check_val("idle_state", 32'(state), 32'd0);
         check_val("idle_no_req", 32'(imem_req), 32'd0);
      end
      imem_ack = 1'b0;
      run = 1'b1;
      step();
      check_val("resume_fetch", 32'(state), 32'd1);
   endtask

   initial begin
      logic [5:0]  op;
      logic [31:0] word;
      logic        park;
      rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      ctrl_reg_we = 1'b0; ctrl_load_pc = 1'b0; ctrl_load_pc_val = '0;
      ctrl_mem_rd = 1'b0; ctrl_mem_wr = 1'b0; dmem_ack = 1'b0;
      m_pc = '0; m_count = '0;
      #23;
      check_val("rst_state", 32'(state), 32'd0);
      check_val("rst_pc", 32'(pc), 32'd0);
      check_val("rst_instr", instr, 32'd0);
      check_val("rst_count", instr_count, 32'd0);
      check_val("rst_strobes", {25'd0, imem_req, dmem_req, dmem_we, rf_we, status_we, illegal_op, err}, 32'd0);
      rst_n = 1'b1;
      run   = 1'b1;
      step();
      check_val("first_fetch", 32'(state), 32'd1);

      do_instr(32'h0422_1800, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, 0, 1'b0);       // ADD
      do_instr({6'h02, 26'd0}, 1'b0, 1'b1, 26'h40, 1'b0, 1'b0, 1, 0, 1'b0);   // JMP 0x40
      do_instr({6'h02, 26'd5}, 1'b0, 1'b1, 26'h3FF_FFFF, 1'b0, 1'b0, 0, 0, 1'b0);
      do_instr({6'h00, 26'd0}, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 0, 1'b0);       // NOP wraps pc
      check_val("pc_wrap", 32'(pc), 32'd0);
      do_instr({6'h05, 26'h123}, 1'b0, 1'b0, '0, 1'b0, 1'b1, 0, 3, 1'b0);    // STR, 8 cycles
      do_instr({6'h0A, 26'h7}, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 0, 1'b0);      // CMP
      do_instr({6'h09, 26'h1}, 1'b1, 1'b1, 26'h99, 1'b1, 1'b0, 0, 0, 1'b0);  // undefined
      do_instr({6'h3F, 26'h2}, 1'b1, 1'b0, '0, 1'b1, 1'b1, 2, 0, 1'b0);      // undefined
      do_instr({6'h16, 26'h3}, 1'b1, 1'b0, '0, 1'b1, 1'b1, 0, 1, 1'b0);      // rd+wr: write wins
      do_instr({6'h03, 26'h4}, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1, 2, 1'b1);      // run drops in MEM
      resume();

      // Async reset in the middle of a fetch.
      imem_ack = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      check_val("midrst_req", 32'(imem_req), 32'd0);
      check_val("midrst_pc", 32'(pc), 32'd0);
      check_val("midrst_state", 32'(state), 32'd0);
      check_val("midrst_count", instr_count, 32'd0);
      m_pc = '0; m_count = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_val("post_rst_fetch", 32'(state), 32'd1);

      for (int i = 0; i < 150; i++) begin
         op   = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 22)) : 6'($urandom_range(0, 63));
         word = {op, 26'($urandom)};
         park = ($urandom_range(0, 9) == 0);
         do_instr(word, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 26'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3), park);
         if (park) resume();
      end

      // Withheld fetch ack.
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
`ifdef SEQ_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("to_wait_state", 32'(state), 32'd1);
      end
      step();
      for (int i = 0; i < 4; i++) begin
         check_val("to_state", 32'(state), 32'd6);
         check_val("to_err", 32'(err), 32'd1);
         check_val("to_req", 32'(imem_req), 32'd0);
         imem_ack = 1'b1;
         step();
      end
`else
      for (int i = 0; i < 10; i++) step();
      check_val("hang_state", 32'(state), 32'd1);
      check_val("hang_err", 32'(err), 32'd0);
      check_val("hang_req", 32'(imem_req), 32'd1);
`endif
      rst_n = 1'b0;
      #1;
      check_val("final_rst_err", 32'(err), 32'd0);
      check_val("final_rst_state", 32'(state), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
